display_arbiter: RTL and testbench

Time-sliced round-robin arbiter that shares the calculator's single 8-LED displayer among several value sources (operand A, operand B, result, status). It takes a snapshot of the granted source's byte and holds it on the displayer input for a minimum window long enough to be read by eye. It then re-arbitrates. It sits between the calculator datapath and the displayer's data input.

---
 rtl/calc_disp_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/display_arbiter.sv | 102 ++++++++++
 tb/tb_display_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display path.
package calc_disp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_e;

   localparam int unsigned NREQ_DEFAULT = 4;

   localparam int unsigned SRC_OPA    = 0;
   localparam int unsigned SRC_OPB    = 1;
   localparam int unsigned SRC_RESULT = 2;
   localparam int unsigned SRC_STATUS = 3;

   // Owner/pointer index width; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_pick
   import calc_disp_pkg::*;
#(
   parameter  int unsigned NREQ = NREQ_DEFAULT,
   localparam int unsigned IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   pointer,
   output logic            any_req,
   output logic [IW-1:0]   grant_idx
);

   int unsigned    pos;
   logic [IW-1:0]  cand;

   always_comb begin
      any_req   = 1'b0;
      grant_idx = '0;
      pos       = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         pos = 32'(pointer) + k;
         if (pos >= NREQ) pos = pos - NREQ;
         cand = IW'(pos);
         if (!any_req && req[cand]) begin
            any_req   = 1'b1;
            grant_idx = cand;
         end
      end
   end

endmodule

// File: rtl/display_arbiter.sv
// Time-sliced round-robin arbiter feeding one byte to the LED displayer; each grant
// snapshots the source byte and holds it for HOLD cycles before re-arbitrating.
module display_arbiter
   import calc_disp_pkg::*;
#(
   parameter  int unsigned NREQ = NREQ_DEFAULT,
   parameter  int unsigned HOLD = 50000000,
   localparam int unsigned IW   = idx_w(NREQ),
   localparam int unsigned CW   = (HOLD <= 1) ? 1 : $clog2(HOLD)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   ack,
   output logic [7:0]        disp_data,
   output logic [IW-1:0]     owner,
   output logic              owner_valid,
   output logic              busy
);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [7:0]        disp_q, disp_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;

   logic              any_req;
   logic [IW-1:0]     grant_idx;
   logic [7:0]        src_byte [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign src_byte[g] = req_data[8*g +: 8];
   end

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req       (req),
      .pointer   (ptr_q),
      .any_req   (any_req),
      .grant_idx (grant_idx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      ack_d   = '0;
      disp_d  = disp_q;
      valid_d = valid_q;
      busy_d  = busy_q;

      if (state_q == SHOW && cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end else if (any_req) begin
         state_d = SHOW;
         cnt_d   = CW'(HOLD - 1);
         ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
         owner_d = grant_idx;
         ack_d   = NREQ'(1) << grant_idx;
         disp_d  = src_byte[grant_idx];
         valid_d = 1'b1;
         busy_d  = 1'b1;
      end else begin
         // Window over with nobody waiting: display content is left as-is.
         state_d = IDLE;
         busy_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         ack_q   <= '0;
         disp_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         ack_q   <= ack_d;
         disp_q  <= disp_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign ack         = ack_q;
   assign disp_data   = disp_q;
   assign owner       = owner_q;
   assign owner_valid = valid_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter with NREQ=4, HOLD=4.
module tb_display_arbiter;
   import calc_disp_pkg::*;

   localparam int unsigned N = 4;
   localparam int unsigned H = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  ack;
   logic [7:0]    disp_data;
   logic [1:0]    owner;
   logic          owner_valid;
   logic          busy;

   typedef struct {
      int         cyc;
      logic [1:0] idx;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   k;
   logic [3:0] oh;

   display_arbiter #(.NREQ(N), .HOLD(H)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .disp_data   (disp_data),
      .owner       (owner),
      .owner_valid (owner_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int cyc, input logic [1:0] idx, input logic [7:0] data);
      exp_t x;
      x.cyc = cyc; x.idx = idx; x.data = data;
      sb.push_back(x);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      k = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b1111;
      req_data = 32'h44332211;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (disp_data !== 8'h00 || ack !== 4'b0 || owner_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state disp=%h ack=%b valid=%b busy=%b expected 00/0000/0/0",
                     disp_data, ack, owner_valid, busy);
         end
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (ack !== 4'b0001 || disp_data !== 8'h11 || owner !== 2'd0 || owner_valid !== 1'b1) begin
         n_err++;
         $display("FAIL reset_first_grant ack=%b disp=%h owner=%0d valid=%b expected 0001/11/0/1",
                  ack, disp_data, owner, owner_valid);
      end
   endtask

   task automatic test_single();
      req = '0;
      do_reset();
      req = 4'b0100;
      req_data = 32'h00A50000;
      push(1, 2'd2, 8'hA5);
      push(5, 2'd2, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         tick(); k++;
         if (ack !== 4'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL single_unexpected_ack cyc=%0d ack=%b expected none", k, ack);
            end else begin
               e = sb.pop_front();
               oh = 4'b0001 << e.idx;
               if (ack !== oh || disp_data !== e.data || owner !== e.idx || k != e.cyc) begin
                  n_err++;
                  $display("FAIL single_grant cyc=%0d ack=%b disp=%h owner=%0d expected cyc=%0d ack=%b disp=%h",
                           k, ack, disp_data, owner, e.cyc, oh, e.data);
               end
            end
         end
         if (k <= 4) begin
            n_cmp++;
            if (busy !== 1'b1 || disp_data !== 8'hA5 || owner !== 2'd2) begin
               n_err++;
               $display("FAIL single_window cyc=%0d busy=%b disp=%h owner=%0d expected 1/a5/2",
                        k, busy, disp_data, owner);
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL single_missing_grants left=%0d expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_all();
      logic [7:0] want;
      req = '0;
      do_reset();
      req = 4'b1111;
      req_data = 32'h44332211;
      push(1, 2'd0, 8'h11);
      push(5, 2'd1, 8'h22);
      push(9, 2'd2, 8'h33);
      push(13, 2'd3, 8'h44);
      push(17, 2'd0, 8'h11);
      for (int i = 0; i < 17; i++) begin
         tick(); k++;
         if (ack !== 4'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL all_unexpected_ack cyc=%0d ack=%b expected none", k, ack);
            end else begin
               e = sb.pop_front();
               oh = 4'b0001 << e.idx;
               if (ack !== oh || disp_data !== e.data || owner !== e.idx || k != e.cyc) begin
                  n_err++;
                  $display("FAIL all_grant cyc=%0d ack=%b disp=%h owner=%0d expected cyc=%0d ack=%b disp=%h",
                           k, ack, disp_data, owner, e.cyc, oh, e.data);
               end
            end
         end
         case (((k - 1) / 4) % 4)
            0: want = 8'h11;
            1: want = 8'h22;
            2: want = 8'h33;
            default: want = 8'h44;
         endcase
         n_cmp++;
         if (disp_data !== want) begin
            n_err++;
            $display("FAIL all_disp cyc=%0d disp=%h expected %h", k, disp_data, want);
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL all_missing_grants left=%0d expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_wrap();
      req = '0;
      do_reset();
      req = 4'b1000;
      req_data = 32'h44000011;
      push(1, 2'd3, 8'h44);
      push(5, 2'd0, 8'h11);
      push(9, 2'd3, 8'h44);
      push(13, 2'd0, 8'h11);
      for (int i = 0; i < 15; i++) begin
         tick(); k++;
         if (k == 1) req = 4'b1001;
         if (ack !== 4'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL wrap_unexpected_ack cyc=%0d ack=%b expected none", k, ack);
            end else begin
               e = sb.pop_front();
               oh = 4'b0001 << e.idx;
               if (ack !== oh || disp_data !== e.data || owner !== e.idx || k != e.cyc) begin
                  n_err++;
                  $display("FAIL wrap_grant cyc=%0d ack=%b disp=%h owner=%0d expected cyc=%0d ack=%b disp=%h",
                           k, ack, disp_data, owner, e.cyc, oh, e.data);
               end
            end
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL wrap_missing_grants left=%0d expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_persist();
      req = '0;
      do_reset();
      req = 4'b0010;
      req_data = 32'h00003C00;
      push(1, 2'd1, 8'h3C);
      for (int i = 0; i < 7; i++) begin
         tick(); k++;
         if (k == 2) begin
            req_data = 32'h0000FF00;
            req = 4'b0000;
         end
         if (ack !== 4'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL persist_unexpected_ack cyc=%0d ack=%b expected none", k, ack);
            end else begin
               e = sb.pop_front();
               oh = 4'b0001 << e.idx;
               if (ack !== oh || disp_data !== e.data || owner !== e.idx || k != e.cyc) begin
                  n_err++;
                  $display("FAIL persist_grant cyc=%0d ack=%b disp=%h owner=%0d expected cyc=%0d ack=%b disp=%h",
                           k, ack, disp_data, owner, e.cyc, oh, e.data);
               end
            end
         end
         n_cmp++;
         if (disp_data !== 8'h3C || owner !== 2'd1 || owner_valid !== 1'b1 || busy !== (k <= 4)) begin
            n_err++;
            $display("FAIL persist_hold cyc=%0d disp=%h owner=%0d valid=%b busy=%b expected 3c/1/1/%b",
                     k, disp_data, owner, owner_valid, busy, (k <= 4));
         end
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL persist_missing_grants left=%0d expected 0", sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset_mid();
      req = '0;
      do_reset();
      req = 4'b1111;
      req_data = 32'h44332211;
      tick();
      tick();
      n_cmp++;
      if (owner !== 2'd0 || busy !== 1'b1 || disp_data !== 8'h11) begin
         n_err++;
         $display("FAIL rstmid_pre owner=%0d busy=%b disp=%h expected 0/1/11", owner, busy, disp_data);
      end
      rst = 1'b1;
      tick();
      n_cmp++;
      if (disp_data !== 8'h00 || busy !== 1'b0 || owner_valid !== 1'b0 || ack !== 4'b0 || owner !== 2'd0) begin
         n_err++;
         $display("FAIL rstmid_state disp=%h busy=%b valid=%b ack=%b owner=%0d expected 00/0/0/0000/0",
                  disp_data, busy, owner_valid, ack, owner);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (ack !== 4'b0001 || owner !== 2'd0 || disp_data !== 8'h11) begin
         n_err++;
         $display("FAIL rstmid_pointer ack=%b owner=%0d disp=%h expected 0001/0/11", ack, owner, disp_data);
      end
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      req_data = '0;
      test_reset();
      test_single();
      test_all();
      test_wrap();
      test_persist();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
